gaplus_hv_timing: RTL
=====================

// Module: gaplus_hv_timing
// PURPOSE
//  Raster timing generator for the Gaplus video pipe; runs on the 6.25MHz pixel clock.
//  Produces PH/PV, HBLANK/VBLANK, H/V/composite sync, an 8-bit frame counter and the CPU
//  VBLANK interrupt (set/ack handshake). PH/PV feed GAPLUS_VIDEO directly.
//  Screen centring offsets (HOFS/VOFS) are tear-free: latched once per frame.
// PARAMETERS
//  H_TOTAL     384  pixels per line; PH counts 0..H_TOTAL-1
//  H_BLK_END    16  HBLANK while PH < H_BLK_END
//  H_BLK_START 304  HBLANK while PH >= H_BLK_START (active width 288)
//  H_SYNC_POS  320  nominal HSYNC start pixel
//  H_SYNC_LEN   32  HSYNC width, pixels
//  V_TOTAL     264  lines per frame; PV counts 0..V_TOTAL-1
//  V_BLK_START 224  VBLANK while PV >= V_BLK_START (active height 224)
//  V_SYNC_POS  236  nominal VSYNC start line
//  V_SYNC_LEN    3  VSYNC width, lines
// PORTS
//  VCLK     in   1  pixel clock 6.25MHz; all state on rising edge
//  RESET    in   1  asynchronous, active-high
//  HOFS     in   4  signed HSYNC shift, -8..+7 pixels
//  VOFS     in   3  signed VSYNC shift, -4..+3 lines
//  IRQ_EN   in   1  VBLANK interrupt enable (CPU latch)
//  IRQ_ACK  in   1  one-VCLK pulse: clears IRQ
//  PH       out  9  horizontal position
//  PV       out  9  vertical position
//  HBLANK   out  1  horizontal blank
//  VBLANK   out  1  vertical blank
//  HSYNC    out  1  active-high horizontal sync
//  VSYNC    out  1  active-high vertical sync
//  CSYNC_N  out  1  composite sync, active-low = ~(HSYNC|VSYNC)
//  FRAME    out  8  frame counter
//  IRQ      out  1  VBLANK interrupt request, level
// BEHAVIOUR
//  Reset decision: RESET, asynchronous, active-high; clock VCLK.
//  Reset values:
//   - PH=0, PV=0, HBLANK=1, VBLANK=0, HSYNC=0, VSYNC=0, CSYNC_N=1, FRAME=0, IRQ=0.
//   - Latched offsets = 0.
//   - RESET mid-frame aborts the line; counting restarts at (0,0) on the first edge after release.
//  Counters:
//   - PH increments every VCLK and wraps H_TOTAL-1 -> 0.
//   - On that wrap PV increments; PV wraps V_TOTAL-1 -> 0.
//   - Frame boundary = cycle where PH=H_TOTAL-1 and PV=V_TOTAL-1. FRAME increments there (wraps 255->0).
//  Offsets: HOFS/VOFS are sampled only at the frame boundary and used for the whole next frame.
//   Mid-frame changes have no effect until then.
//  Outputs are registered and derived from the next-state counts, so all outputs align with PH/PV (zero skew):
//   - HBLANK = (PH<H_BLK_END)|(PH>=H_BLK_START).
//   - VBLANK = PV>=V_BLK_START.
//   - HSYNC  = PH in [H_SYNC_POS+hofs, H_SYNC_POS+hofs+H_SYNC_LEN). Range is 312..358, no wrap.
//   - VSYNC  = PV in [V_SYNC_POS+vofs, V_SYNC_POS+vofs+V_SYNC_LEN). Range is 232..241, no wrap.
//   - Offset arithmetic: 10-bit signed, sign-extended.
//  IRQ handshake:
//   - Set event: the cycle PH becomes 0 with PV becoming V_BLK_START, and IRQ_EN=1.
//   - IRQ stays 1 until IRQ_ACK=1, or IRQ_EN=0 (combinational clear, next edge).
//   - Set and ACK on the same edge: set wins, IRQ stays 1.
//   - IRQ_EN rising while PV is already in VBLANK does not raise IRQ; wait for the next frame.
//  No other state; one frame = 384*264 = 101376 VCLK (~61.7Hz).
// TESTING
//  T1 reset: hold RESET 5 clk.
//     -> PH=PV=0, HBLANK=1, CSYNC_N=1, IRQ=0.
//     Release -> PH=1 after 1 edge.
//  T2 wrap: run 101376 clk from reset.
//     -> PH 383->0 with PV+1 each line, PV 263->0, FRAME 0->1.
//     HBLANK edges at PH 16/304; VBLANK rises at PV 224, falls at PV 0.
//  T3 sync/offset: HOFS=-8, VOFS=+3 written at PV=100.
//     -> current frame HSYNC at 320..351, VSYNC 236..238.
//     -> next frame HSYNC 312..343, VSYNC 239..241.
//  T4 IRQ: IRQ_EN=1.
//     -> IRQ rises with PV=224,PH=0. ACK at PV=230 -> IRQ=0 next edge, no re-set until next frame.
//  T5 race: ACK asserted exactly on the set edge -> IRQ=1.
//     IRQ_EN=0 while IRQ=1 -> IRQ=0 next edge.
//  T6 reset mid-frame: assert RESET at PV=150,PH=200 for 1 clk.
//     -> all outputs at reset values immediately; FRAME=0; restart at (0,0).

Source files
------------

// File: rtl/gaplus_hv_timing.sv
// Gaplus raster timing: pixel/line counters, blanking, sync, frame counter and VBLANK IRQ.
// Every output is registered from the next-state counts so it lines up with PH/PV.
module gaplus_hv_timing #(
  parameter int H_TOTAL     = 384,
  parameter int H_BLK_END   = 16,
  parameter int H_BLK_START = 304,
  parameter int H_SYNC_POS  = 320,
  parameter int H_SYNC_LEN  = 32,
  parameter int V_TOTAL     = 264,
  parameter int V_BLK_START = 224,
  parameter int V_SYNC_POS  = 236,
  parameter int V_SYNC_LEN  = 3
) (
  input  logic       VCLK,
  input  logic       RESET,
  input  logic [3:0] HOFS,
  input  logic [2:0] VOFS,
  input  logic       IRQ_EN,
  input  logic       IRQ_ACK,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       CSYNC_N,
  output logic [7:0] FRAME,
  output logic       IRQ
);

  localparam logic [8:0]        H_LAST      = 9'(H_TOTAL - 1);
  localparam logic [8:0]        V_LAST      = 9'(V_TOTAL - 1);
  localparam logic [8:0]        H_BLK_END_C = 9'(H_BLK_END);
  localparam logic [8:0]        H_BLK_STA_C = 9'(H_BLK_START);
  localparam logic [8:0]        V_BLK_STA_C = 9'(V_BLK_START);
  localparam logic signed [9:0] H_SYNC_POS_S = 10'(H_SYNC_POS);
  localparam logic signed [9:0] H_SYNC_LEN_S = 10'(H_SYNC_LEN);
  localparam logic signed [9:0] V_SYNC_POS_S = 10'(V_SYNC_POS);
  localparam logic signed [9:0] V_SYNC_LEN_S = 10'(V_SYNC_LEN);

  function automatic logic signed [9:0] sext_h(input logic [3:0] v);
    return $signed({{6{v[3]}}, v});
  endfunction

  function automatic logic signed [9:0] sext_v(input logic [2:0] v);
    return $signed({{7{v[2]}}, v});
  endfunction

  // Half-open window [start, start+len) on a position count.
  function automatic logic in_win(input logic [8:0] pos,
                                  input logic signed [9:0] start,
                                  input logic signed [9:0] len);
    logic signed [9:0] p;
    p = $signed({1'b0, pos});
    return (p >= start) && (p < (start + len));
  endfunction

  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] hofs_q, hofs_d;
  logic [2:0] vofs_q, vofs_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       csync_n_q, csync_n_d;
  logic       irq_q, irq_d;

  logic              line_end;
  logic              frame_end;
  logic              irq_set;
  logic signed [9:0] hs_start;
  logic signed [9:0] vs_start;

  always_comb begin
    line_end  = (ph_q == H_LAST);
    frame_end = line_end && (pv_q == V_LAST);

    ph_d = line_end ? 9'd0 : ph_q + 9'd1;
    pv_d = pv_q;
    if (line_end) begin
      pv_d = (pv_q == V_LAST) ? 9'd0 : pv_q + 9'd1;
    end
    frame_d = frame_end ? frame_q + 8'd1 : frame_q;

    // Offsets only change across the frame boundary so a frame never tears.
    hofs_d = frame_end ? HOFS : hofs_q;
    vofs_d = frame_end ? VOFS : vofs_q;

    hs_start = H_SYNC_POS_S + sext_h(hofs_d);
    vs_start = V_SYNC_POS_S + sext_v(vofs_d);

    hblank_d  = (ph_d < H_BLK_END_C) || (ph_d >= H_BLK_STA_C);
    vblank_d  = (pv_d >= V_BLK_STA_C);
    hsync_d   = in_win(ph_d, hs_start, H_SYNC_LEN_S);
    vsync_d   = in_win(pv_d, vs_start, V_SYNC_LEN_S);
    csync_n_d = ~(hsync_d | vsync_d);

    // A set on the same edge as an acknowledge takes priority.
    irq_set = (ph_d == 9'd0) && (pv_d == V_BLK_STA_C) && IRQ_EN;
    irq_d   = irq_q;
    if (IRQ_ACK || !IRQ_EN) begin
      irq_d = 1'b0;
    end
    if (irq_set) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge VCLK or posedge RESET) begin
    if (RESET) begin
      ph_q      <= 9'd0;
      pv_q      <= 9'd0;
      frame_q   <= 8'd0;
      hofs_q    <= 4'd0;
      vofs_q    <= 3'd0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      csync_n_q <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      frame_q   <= frame_d;
      hofs_q    <= hofs_d;
      vofs_q    <= vofs_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      csync_n_q <= csync_n_d;
      irq_q     <= irq_d;
    end
  end

  assign PH      = ph_q;
  assign PV      = pv_q;
  assign HBLANK  = hblank_q;
  assign VBLANK  = vblank_q;
  assign HSYNC   = hsync_q;
  assign VSYNC   = vsync_q;
  assign CSYNC_N = csync_n_q;
  assign FRAME   = frame_q;
  assign IRQ     = irq_q;

endmodule
